session_table: RTL and testbench

SESSION_TABLE -- requirements
Module: session_table

---
 rtl/toe_pkg.sv | 35 +++
 rtl/session_table.sv | 199 +++++++++++++++++++
 tb/tb_session_table.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/toe_pkg.sv
// Shared definitions for the TCP offload session table: request codes,
// result codes, FSM states and the connection key layout.
package toe_pkg;

    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        RQ_IDLE   = 2'b00,
        RQ_INSERT = 2'b01,
        RQ_LOOKUP = 2'b10,
        RQ_DELETE = 2'b11
    } rq_e;

    localparam logic [7:0] RET_NONE     = 8'h00;
    localparam logic [7:0] RET_INSERTED = 8'h01;
    localparam logic [7:0] RET_FOUND    = 8'h02;
    localparam logic [7:0] RET_DELETED  = 8'h03;
    localparam logic [7:0] RET_MISS     = 8'h80;
    localparam logic [7:0] RET_FULL     = 8'h81;
    localparam logic [7:0] RET_DUP      = 8'h82;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic [15:0] port_src;
        logic [15:0] port_dst;
    } key_t;

endpackage

// File: rtl/session_table.sv
// Connection table with a sequential one-entry-per-cycle scan for insert,
// lookup and delete of TCP/IPv4 four-tuples.
module session_table
    import toe_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               st_rq,
    input  logic [7:0]               st_id_in,
    input  logic [31:0]              st_ip_src,
    input  logic [31:0]              st_ip_dst,
    input  logic [23:0]              st_mac_src,
    input  logic [23:0]              st_mac_dst,
    input  logic [15:0]              st_port_src,
    input  logic [15:0]              st_port_dst,
    output logic [7:0]               st_return,
    output logic [7:0]               st_hit_id,
    output logic [$clog2(DEPTH):0]   st_count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    state_e          state_reg, state_next;

    rq_e             rq_reg;
    key_t            key_reg;
    logic [23:0]     mac_src_reg, mac_dst_reg;
    logic [7:0]      id_reg;

    logic [IW-1:0]   scan_idx_reg, scan_idx_next;
    logic            free_found_reg, free_found_next;
    logic [IW-1:0]   free_idx_reg, free_idx_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [7:0]      ret_reg, ret_next;
    logic [7:0]      hit_reg, hit_next;

    // Entry storage: MACs travel with the entry but never take part in matching.
    key_t            key_mem     [DEPTH];
    logic [23:0]     mac_src_mem [DEPTH];
    logic [23:0]     mac_dst_mem [DEPTH];
    logic [7:0]      id_mem      [DEPTH];
    logic [DEPTH-1:0] valid_reg, wr_sel, clr_sel;

    logic            latch_en, wr_en, clr_en;
    logic [IW-1:0]   wr_slot;
    logic            entry_hit, scan_last, free_avail;
    logic [IW-1:0]   free_slot;

    // Single read port addressed by the scan index, compared inline.
    assign entry_hit  = valid_reg[scan_idx_reg] && (key_mem[scan_idx_reg] == key_reg);
    assign scan_last  = (scan_idx_reg == IW'(DEPTH - 1));
    assign free_avail = free_found_reg || !valid_reg[scan_idx_reg];
    assign free_slot  = free_found_reg ? free_idx_reg : scan_idx_reg;
    assign wr_slot    = free_slot;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (st_rq != RQ_IDLE)     state_next = ST_SCAN;
            ST_SCAN: if (entry_hit || scan_last) state_next = ST_DONE;
            ST_DONE: if (st_rq == RQ_IDLE)     state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        latch_en        = 1'b0;
        wr_en           = 1'b0;
        clr_en          = 1'b0;
        scan_idx_next   = scan_idx_reg;
        free_found_next = free_found_reg;
        free_idx_next   = free_idx_reg;
        count_next      = count_reg;
        ret_next        = ret_reg;
        hit_next        = hit_reg;
        case (state_reg)
            ST_IDLE: begin
                if (st_rq != RQ_IDLE) begin
                    latch_en        = 1'b1;
                    scan_idx_next   = '0;
                    free_found_next = 1'b0;
                    free_idx_next   = '0;
                end
            end
            ST_SCAN: begin
                if (entry_hit) begin
                    hit_next = id_mem[scan_idx_reg];
                    case (rq_reg)
                        RQ_LOOKUP: ret_next = RET_FOUND;
                        RQ_INSERT: ret_next = RET_DUP;
                        RQ_DELETE: begin
                            ret_next = RET_DELETED;
                            clr_en   = 1'b1;
                            if (count_reg != '0) count_next = count_reg - 1'b1;
                        end
                        default:   ret_next = RET_MISS;
                    endcase
                end else if (scan_last) begin
                    if (rq_reg == RQ_INSERT && free_avail && count_reg < CW'(DEPTH)) begin
                        wr_en      = 1'b1;
                        ret_next   = RET_INSERTED;
                        hit_next   = id_reg;
                        count_next = count_reg + 1'b1;
                    end else begin
                        ret_next = (rq_reg == RQ_INSERT) ? RET_FULL : RET_MISS;
                        hit_next = 8'h00;
                    end
                end else begin
                    scan_idx_next = scan_idx_reg + 1'b1;
                    // Remember the lowest empty slot for a possible insert.
                    if (!valid_reg[scan_idx_reg] && !free_found_reg) begin
                        free_found_next = 1'b1;
                        free_idx_next   = scan_idx_reg;
                    end
                end
            end
            ST_DONE: begin
                if (st_rq == RQ_IDLE) begin
                    ret_next = RET_NONE;
                    hit_next = 8'h00;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_idx_reg   <= '0;
            free_found_reg <= 1'b0;
            free_idx_reg   <= '0;
            count_reg      <= '0;
            ret_reg        <= RET_NONE;
            hit_reg        <= 8'h00;
        end else begin
            scan_idx_reg   <= scan_idx_next;
            free_found_reg <= free_found_next;
            free_idx_reg   <= free_idx_next;
            count_reg      <= count_next;
            ret_reg        <= ret_next;
            hit_reg        <= hit_next;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_en) begin
            rq_reg           <= rq_e'(st_rq);
            key_reg.ip_src   <= st_ip_src;
            key_reg.ip_dst   <= st_ip_dst;
            key_reg.port_src <= st_port_src;
            key_reg.port_dst <= st_port_dst;
            mac_src_reg      <= st_mac_src;
            mac_dst_reg      <= st_mac_dst;
            id_reg           <= st_id_in;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign wr_sel[gi]  = wr_en  && (wr_slot == IW'(gi));
            assign clr_sel[gi] = clr_en && (scan_idx_reg == IW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= (valid_reg | wr_sel) & ~clr_sel;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                key_mem[i]     <= key_reg;
                mac_src_mem[i] <= mac_src_reg;
                mac_dst_mem[i] <= mac_dst_reg;
                id_mem[i]      <= id_reg;
            end
        end
    end

    assign st_return = ret_reg;
    assign st_hit_id = hit_reg;
    assign st_count  = count_reg;

endmodule

// File: tb/tb_session_table.sv
// Directed bench for session_table: insert/lookup/delete, duplicates, full
// table, slot reuse, mid-scan input changes and reset during a scan.
module tb_session_table;
    import toe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  st_rq;
    logic [7:0]  st_id_in;
    logic [31:0] st_ip_src, st_ip_dst;
    logic [23:0] st_mac_src, st_mac_dst;
    logic [15:0] st_port_src, st_port_dst;
    logic [7:0]  st_return, st_hit_id;
    logic [3:0]  st_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    session_table #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .st_rq(st_rq), .st_id_in(st_id_in),
        .st_ip_src(st_ip_src), .st_ip_dst(st_ip_dst),
        .st_mac_src(st_mac_src), .st_mac_dst(st_mac_dst),
        .st_port_src(st_port_src), .st_port_dst(st_port_dst),
        .st_return(st_return), .st_hit_id(st_hit_id), .st_count(st_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_tuple(input logic [31:0] src, input logic [31:0] dst,
                             input logic [15:0] ps, input logic [15:0] pd);
        st_ip_src   = src;
        st_ip_dst   = dst;
        st_port_src = ps;
        st_port_dst = pd;
        st_mac_src  = src[23:0] ^ 24'hA5A5A5;
        st_mac_dst  = dst[23:0] ^ 24'h5A5A5A;
    endtask

    // Issue a request at a negedge, measure edges after the sampling edge,
    // check result, hold for one edge, then drop st_rq and check clearing.
    task automatic run_req(input string tag, input logic [1:0] rq, input logic [7:0] id,
                           input logic [31:0] src, input logic [31:0] dst,
                           input logic [15:0] ps, input logic [15:0] pd,
                           input logic [7:0] exp_ret, input bit chk_hit,
                           input logic [7:0] exp_hit, input int exp_lat,
                           input int exp_cnt);
        int edges;
        edges = 0;
        @(negedge clk);
        set_tuple(src, dst, ps, pd);
        st_id_in = id;
        st_rq    = rq;
        do begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end while (st_return == 8'h00 && edges < 40);
        $display("%s: rq=%0d ret=%02h hit=%02h count=%0d latency=%0d",
                 tag, rq, st_return, st_hit_id, st_count, edges - 1);
        check({tag, " ret"}, 32'(st_return), 32'(exp_ret));
        check({tag, " latency"}, 32'(edges - 1), 32'(exp_lat));
        if (chk_hit) check({tag, " hit"}, 32'(st_hit_id), 32'(exp_hit));
        check({tag, " count"}, 32'(st_count), 32'(exp_cnt));
        @(posedge clk);
        @(negedge clk);
        check({tag, " hold"}, 32'(st_return), 32'(exp_ret));
        st_rq = 2'b00;
        @(posedge clk);
        @(negedge clk);
        check({tag, " clear"}, 32'({st_return, st_hit_id}), 32'h0);
    endtask

    localparam logic [31:0] IP_A = 32'h0A000001;
    localparam logic [31:0] IP_B = 32'h0A000002;

    initial begin
        int edges;
        rst = 1'b0;
        st_rq = 2'b00;
        st_id_in = 8'h00;
        set_tuple(32'h0, 32'h0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ret", 32'(st_return), 32'h0);
        check("reset hit", 32'(st_hit_id), 32'h0);
        check("reset count", 32'(st_count), 32'h0);
        rst = 1'b1;

        run_req("ins_t1", 2'b01, 8'h11, IP_A, IP_B, 16'd80, 16'd5000, RET_INSERTED, 1, 8'h11, 8, 1);
        run_req("lkp_t1", 2'b10, 8'h00, IP_A, IP_B, 16'd80, 16'd5000, RET_FOUND, 1, 8'h11, 1, 1);
        run_req("lkp_miss", 2'b10, 8'h00, IP_A, IP_B, 16'd80, 16'd5001, RET_MISS, 1, 8'h00, 8, 1);
        run_req("ins_dup", 2'b01, 8'h22, IP_A, IP_B, 16'd80, 16'd5000, RET_DUP, 0, 8'h00, 1, 1);
        run_req("del_t1", 2'b11, 8'h00, IP_A, IP_B, 16'd80, 16'd5000, RET_DELETED, 1, 8'h11, 1, 0);
        run_req("del_again", 2'b11, 8'h00, IP_A, IP_B, 16'd80, 16'd5000, RET_MISS, 1, 8'h00, 8, 0);

        for (int i = 0; i < 8; i++) begin
            run_req($sformatf("fill%0d", i), 2'b01, 8'(8'h40 + i), 32'hC0A80000 + 32'(i),
                    32'hC0A800FE, 16'(1000 + i), 16'd2000, RET_INSERTED, 1, 8'(8'h40 + i), 8, i + 1);
        end
        run_req("ins_full", 2'b01, 8'h50, 32'hC0A80009, 32'hC0A800FE, 16'd1009, 16'd2000,
                RET_FULL, 1, 8'h00, 8, 8);
        run_req("del_slot3", 2'b11, 8'h00, 32'hC0A80003, 32'hC0A800FE, 16'd1003, 16'd2000,
                RET_DELETED, 1, 8'h43, 4, 7);
        run_req("ins_reuse", 2'b01, 8'h99, 32'h0B0B0B0B, 32'h0C0C0C0C, 16'd7, 16'd8,
                RET_INSERTED, 1, 8'h99, 8, 8);
        run_req("lkp_reuse", 2'b10, 8'h00, 32'h0B0B0B0B, 32'h0C0C0C0C, 16'd7, 16'd8,
                RET_FOUND, 1, 8'h99, 4, 8);

        // Lookup of slot 6 with the tuple corrupted and st_rq dropped mid-scan.
        @(negedge clk);
        set_tuple(32'hC0A80006, 32'hC0A800FE, 16'd1006, 16'd2000);
        st_rq = 2'b10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        st_ip_src = 32'hDEADBEEF;
        st_rq = 2'b00;
        edges = 2;
        do begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end while (st_return == 8'h00 && edges < 40);
        $display("midscan: ret=%02h hit=%02h latency=%0d", st_return, st_hit_id, edges);
        check("midscan ret", 32'(st_return), 32'(RET_FOUND));
        check("midscan hit", 32'(st_hit_id), 32'h46);
        check("midscan latency", 32'(edges), 32'd7);
        @(posedge clk);
        @(negedge clk);
        check("midscan clear", 32'({st_return, st_hit_id}), 32'h0);

        // Reset while an insert scan sits at index 5.
        @(negedge clk);
        set_tuple(32'h01020304, 32'h05060708, 16'd11, 16'd12);
        st_id_in = 8'h77;
        st_rq = 2'b01;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        st_rq = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        $display("reset_midscan: ret=%02h hit=%02h count=%0d", st_return, st_hit_id, st_count);
        check("rstscan ret", 32'(st_return), 32'h0);
        check("rstscan hit", 32'(st_hit_id), 32'h0);
        check("rstscan count", 32'(st_count), 32'h0);
        run_req("rst_lkp_new", 2'b10, 8'h00, 32'h01020304, 32'h05060708, 16'd11, 16'd12,
                RET_MISS, 1, 8'h00, 8, 0);
        run_req("rst_lkp_old", 2'b10, 8'h00, 32'hC0A80000, 32'hC0A800FE, 16'd1000, 16'd2000,
                RET_MISS, 1, 8'h00, 8, 0);
        run_req("rst_ins", 2'b01, 8'h77, 32'h01020304, 32'h05060708, 16'd11, 16'd12,
                RET_INSERTED, 1, 8'h77, 8, 1);
        run_req("rst_lkp", 2'b10, 8'h00, 32'h01020304, 32'h05060708, 16'd11, 16'd12,
                RET_FOUND, 1, 8'h77, 1, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
